// File: rtl/parity_frame_tx.sv
// Serial parity-frame transmitter: shifts a parallel word out one bit per clock
// and appends a generated parity bit, with back-to-back frame support.
module parity_frame_tx #(
  parameter int unsigned DATA_W    = 8,
  parameter bit          ODD       = 1'b0,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load,
  output logic              ready,
  output logic              out,
  output logic              out_valid,
  output logic              par_bit,
  output logic              frame_done,
  output logic              busy
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                acc_q, acc_d;
  logic                head;
  logic                accept;

  assign head   = LSB_FIRST ? shift_q[0] : shift_q[DATA_W-1];
  assign accept = load & ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  // Outputs depend on state_q only; accept only steers the next state.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    ready      = 1'b0;
    out        = 1'b0;
    out_valid  = 1'b0;
    par_bit    = 1'b0;
    frame_done = 1'b0;
    busy       = 1'b1;

    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
        busy  = 1'b0;
        if (accept) begin
          shift_d = data_in;
          cnt_d   = '0;
          acc_d   = 1'b0;
          state_d = StData;
        end
      end
      StData: begin
        out       = head;
        out_valid = 1'b1;
        acc_d     = acc_q ^ head;
        shift_d   = LSB_FIRST ? (shift_q >> 1) : (shift_q << 1);
        cnt_d     = cnt_q + CntW'(1);
        if (cnt_q == CntW'(DATA_W - 1)) begin
          state_d = StParity;
        end
      end
      StParity: begin
        ready      = 1'b1;
        out        = acc_q ^ ODD;
        out_valid  = 1'b1;
        par_bit    = 1'b1;
        frame_done = 1'b1;
        if (accept) begin
          shift_d = data_in;
          cnt_d   = '0;
          acc_d   = 1'b0;
          state_d = StData;
        end else begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Bench for parity_frame_tx: three parameter variants share one stimulus stream and
// are checked every cycle against a frame-level model plus literal frame values.
module tb_parity_frame_tx;

  localparam int unsigned DATA_W = 8;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] data_in;
  logic              load;

  logic ready_s[3], out_s[3], out_valid_s[3], par_bit_s[3], frame_done_s[3], busy_s[3];

  int tests  = 0;
  int failed = 0;

  parity_frame_tx #(.DATA_W(DATA_W), .ODD(1'b0), .LSB_FIRST(1'b1)) u_even_lsb (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load), .ready(ready_s[0]),
    .out(out_s[0]), .out_valid(out_valid_s[0]), .par_bit(par_bit_s[0]),
    .frame_done(frame_done_s[0]), .busy(busy_s[0])
  );

  parity_frame_tx #(.DATA_W(DATA_W), .ODD(1'b1), .LSB_FIRST(1'b1)) u_odd_lsb (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load), .ready(ready_s[1]),
    .out(out_s[1]), .out_valid(out_valid_s[1]), .par_bit(par_bit_s[1]),
    .frame_done(frame_done_s[1]), .busy(busy_s[1])
  );

  parity_frame_tx #(.DATA_W(DATA_W), .ODD(1'b0), .LSB_FIRST(1'b0)) u_even_msb (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load), .ready(ready_s[2]),
    .out(out_s[2]), .out_valid(out_valid_s[2]), .par_bit(par_bit_s[2]),
    .frame_done(frame_done_s[2]), .busy(busy_s[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transmitted sequence of one frame; bit k of the result is the k-th bit on the wire.
  function automatic logic [DATA_W:0] frame_bits(input logic [DATA_W-1:0] w, input bit odd,
                                                 input bit lsb);
    logic [DATA_W:0] f;
    int ones;
    ones = 0;
    for (int i = 0; i < DATA_W; i++) begin
      ones += int'(w[i]);
      f[i] = lsb ? w[i] : w[DATA_W-1-i];
    end
    f[DATA_W] = ((ones % 2) == 1) ^ odd;
    return f;
  endfunction

  // Model: cycles left in the current frame (0 = idle) and the frame being sent.
  int unsigned     remaining;
  logic [DATA_W:0] exp_frame[3];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining = 0;
    end else if (load && remaining <= 1) begin
      exp_frame[0] = frame_bits(data_in, 1'b0, 1'b1);
      exp_frame[1] = frame_bits(data_in, 1'b1, 1'b1);
      exp_frame[2] = frame_bits(data_in, 1'b0, 1'b0);
      remaining = DATA_W + 1;
    end else if (remaining > 0) begin
      remaining = remaining - 1;
    end
  end

  logic [DATA_W:0] cap[3];
  int run_len, run_max, ready_in_data;

  always @(negedge clk) begin
    logic e_act, e_par, e_out;
    int unsigned k;
    e_act = (remaining > 0);
    e_par = (remaining == 1);
    k     = e_act ? (DATA_W + 1 - remaining) : 0;
    for (int i = 0; i < 3; i++) begin
      e_out = e_act ? exp_frame[i][k] : 1'b0;
      check($sformatf("out[%0d]", i), 32'(out_s[i]), 32'(e_out));
      check($sformatf("out_valid[%0d]", i), 32'(out_valid_s[i]), 32'(e_act));
      check($sformatf("par_bit[%0d]", i), 32'(par_bit_s[i]), 32'(e_par));
      check($sformatf("frame_done[%0d]", i), 32'(frame_done_s[i]), 32'(e_par));
      check($sformatf("busy[%0d]", i), 32'(busy_s[i]), 32'(e_act));
      check($sformatf("ready[%0d]", i), 32'(ready_s[i]), 32'(!e_act || e_par));
      if (out_valid_s[i]) cap[i] = {out_s[i], cap[i][DATA_W:1]};
    end
    if (out_valid_s[0]) run_len++;
    else run_len = 0;
    if (run_len > run_max) run_max = run_len;
    if (out_valid_s[0] && !par_bit_s[0] && ready_s[0]) ready_in_data++;
  end

  // Waits (bounded) for ready at a negedge; caller holds load/data_in.
  task automatic wait_ready(input string name);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (ready_s[0]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check({name, "_ready_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic send(input logic [DATA_W-1:0] w, input string name);
    data_in = w;
    load    = 1'b1;
    wait_ready(name);
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    load    = 1'b0;
    data_in = '0;
    run_len = 0;
    run_max = 0;
    ready_in_data = 0;
    for (int i = 0; i < 3; i++) begin
      cap[i] = '0;
      exp_frame[i] = '0;
    end

    // Literal pins on the model.
    check("model_b5_even_lsb", 32'(frame_bits(8'hB5, 1'b0, 1'b1)), 32'h1B5);
    check("model_b5_odd_lsb", 32'(frame_bits(8'hB5, 1'b1, 1'b1)), 32'h0B5);
    check("model_b5_even_msb", 32'(frame_bits(8'hB5, 1'b0, 1'b0)), 32'h1AD);
    check("model_0f_even_lsb", 32'(frame_bits(8'h0F, 1'b0, 1'b1)), 32'h00F);
    check("model_00_odd_lsb", 32'(frame_bits(8'h00, 1'b1, 1'b1)), 32'h100);

    // Load is ignored during reset.
    load    = 1'b1;
    data_in = 8'hFF;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid_s[0]), 32'd0);
    check("rst_ready", 32'(ready_s[0]), 32'd1);
    check("rst_busy", 32'(busy_s[0]), 32'd0);
    load = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // Single frame, all three variants.
    send(8'hB5, "t1");
    idle(12);
    check("t1_even_lsb", 32'(cap[0]), 32'h1B5);
    check("t1_checker_zero", 32'(^cap[0]), 32'd0);
    check("t2_odd_lsb", 32'(cap[1]), 32'h0B5);
    check("t3_even_msb", 32'(cap[2]), 32'h1AD);

    send(8'h00, "t2z");
    idle(12);
    check("t2_zero_even", 32'(cap[0]), 32'h000);
    check("t2_zero_odd", 32'(cap[1]), 32'h100);

    // Back-to-back: second word accepted on the parity-cycle edge.
    run_max = 0;
    ready_in_data = 0;
    data_in = 8'hB5;
    load    = 1'b1;
    wait_ready("t4a");
    @(posedge clk);
    #1 data_in = 8'h0F;
    wait_ready("t4b");
    @(posedge clk);
    #1 load = 1'b0;
    idle(12);
    check("t4_run_len", 32'(run_max), 32'd18);
    check("t4_second_frame", 32'(cap[0]), 32'h00F);
    check("t4_ready_in_data", 32'(ready_in_data), 32'd0);

    // Asynchronous reset during data bit 4.
    send(8'hB5, "t5a");
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t5_async_out_valid[%0d]", i), 32'(out_valid_s[i]), 32'd0);
      check($sformatf("t5_async_busy[%0d]", i), 32'(busy_s[i]), 32'd0);
      check($sformatf("t5_async_ready[%0d]", i), 32'(ready_s[i]), 32'd1);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    idle(2);
    send(8'h01, "t5b");
    idle(12);
    check("t5_clean_even_lsb", 32'(cap[0]), 32'h101);
    check("t5_clean_odd_lsb", 32'(cap[1]), 32'h001);
    check("t5_clean_even_msb", 32'(cap[2]), 32'h180);

    // Load held through DATA with data_in churning.
    data_in = 8'h3C;
    load    = 1'b1;
    wait_ready("t6a");
    @(posedge clk);
    for (int i = 0; i < DATA_W; i++) begin
      #1 data_in = DATA_W'($urandom);
      @(posedge clk);
    end
    #1 data_in = 8'hC3;
    wait_ready("t6b");
    @(posedge clk);
    #1 load = 1'b0;
    check("t6_first_frame", 32'(cap[0]), 32'h03C);
    idle(12);
    check("t6_second_frame", 32'(cap[0]), 32'h0C3);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/parity_frame_tx.md
Name: parity_frame_tx

Overview:
- Serial transmitter for the parity-protected bit stream consumed by the team's serial parity checker.
- Accepts a parallel data word over a valid/ready handshake and shifts it out one bit per clock.
- Appends one generated parity bit per frame, so a downstream running-parity checker returns to its "zero" state at every frame boundary (even mode).
- Sits between a word-level producer and the single-bit serial link.

Parameters:
- DATA_W, 8: data bits per frame (legal range 2..32).
- ODD, 0: 0 = even parity (total ones in frame, data plus parity, is even); 1 = odd parity.
- LSB_FIRST, 1: 1 = data bit 0 is sent first; 0 = bit DATA_W-1 is sent first.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  DATA_W  word to transmit; sampled only on an accepted load.
- load  input  1  producer valid.
- ready  output  1  transmitter can accept a word this cycle.
- out  output  1  serial data/parity bit.
- out_valid  output  1  out carries a frame bit this cycle.
- par_bit  output  1  flag: high during the parity-bit cycle of a frame.
- frame_done  output  1  one-cycle pulse, coincident with the parity-bit cycle.
- busy  output  1  frame in progress (state != IDLE).

Behaviour:
- Single clock domain; all state updates on posedge clk.
- rst asserted (any time, asynchronously) forces state=IDLE, shift register=0, bit counter=0, parity accumulator=0.
  - Outputs during and after reset: out=0, out_valid=0, par_bit=0, frame_done=0, busy=0, ready=1.
  - load is ignored while rst is high.
- States:
  - IDLE: no frame active.
  - DATA: shifting data bits.
  - PARITY: driving the parity bit.
- ready = (state==IDLE) or (state==PARITY). Ready is high in PARITY so frames can be sent back to back.
- Accept = load and ready at a rising edge. On accept:
  - data_in is captured.
  - Bit counter is cleared.
  - Accumulator is cleared.
  - State becomes DATA.
- DATA:
  - out = current head bit of the shift register (bit 0 if LSB_FIRST, else bit DATA_W-1); out_valid=1.
  - Each edge: accumulator ^= out, register shifts toward the head, counter increments.
  - After DATA_W data cycles, go to PARITY.
- PARITY (exactly one cycle):
  - out = accumulator XOR ODD; out_valid=1, par_bit=1, frame_done=1.
  - Next state: DATA if accept occurs this edge, else IDLE.
- Latency and throughput:
  - First data bit appears on out the cycle after the accept edge.
  - Frame length is DATA_W+1 cycles with out_valid continuously high.
  - Back-to-back frames have zero idle cycles between them.
- IDLE: out=0, out_valid=0, par_bit=0, frame_done=0.
- Outputs are functions of registered state only; there is no combinational path from data_in or load to out or out_valid. ready is a function of state only.
- load asserted in DATA is ignored and not queued; the producer holds it until ready.
- Counter width is $clog2(DATA_W+1). The counter never wraps mid-frame.
- Reset mid-frame aborts the frame immediately. No parity bit is emitted for the aborted frame. The next accepted word starts a clean frame with the accumulator cleared.

Test Plan:
1. DATA_W=8, ODD=0, LSB_FIRST=1; load 0xB5 from IDLE.
   - out over 9 cycles = 1,0,1,0,1,1,0,1 then parity 1.
   - frame_done and par_bit high only on cycle 9; then IDLE with out_valid=0.
   - A checker model fed this stream ends in state 0.
2. Same word with ODD=1.
   - Parity bit = 0.
   - Word 0x00 gives parity 0 with ODD=0 and parity 1 with ODD=1.
3. LSB_FIRST=0, load 0xB5.
   - out = 1,0,1,1,0,1,0,1 then parity 1.
4. Back-to-back: load 0xB5, then hold load with 0x0F so it is accepted on the parity-cycle edge.
   - out_valid high for 18 consecutive cycles.
   - Second frame = 1,1,1,1,0,0,0,0 then parity 0.
   - ready low throughout both DATA phases.
5. Assert rst asynchronously mid-cycle during data bit 4 of 0xB5.
   - out_valid=0, busy=0, ready=1 immediately, without waiting for a clock edge.
   - After release, load 0x01 yields 1,0,0,0,0,0,0,0 then parity 1.
6. load held high throughout DATA of a frame.
   - No extra capture occurs; data_in changes mid-frame do not alter the transmitted bits.
   - The next word is taken exactly at the parity-cycle edge.
